lsu: RTL and testbench

Load/store unit that acts as the initiator for the byte-masked data RAM: it accepts one load or store request at a time from the core pipeline and drives the RAM's read port 1 and write port. It converts a byte address plus access size into 64-bit word addresses and byte masks. Accesses that cross an 8-byte word boundary are split into two RAM cycles. Loaded data is aligned, then sign- or zero-extended, before being returned on a response handshake.

---
 rtl/lsu.sv | 187 ++++++++++++++++++
 tb/tb_lsu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: single-outstanding load/store initiator for the byte-masked
// data RAM. Splits accesses that straddle a 64-bit word into two RAM cycles,
// lane-aligns store data and aligns/extends load data for the response.
module lsu #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int MASK_WIDTH = DATA_WIDTH >> 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic                  o_rd_en,
   output logic [MASK_WIDTH-1:0] o_rd_mask,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic [ADDR_WIDTH-1:0] o_wr_addr,
   output logic                  o_wr_en,
   output logic [MASK_WIDTH-1:0] o_wr_mask,
   output logic [DATA_WIDTH-1:0] o_wr_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC0,
      S_ACC1,
      S_RESP
   } state_e;

   state_e                  state_q, state_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [1:0]              size_q, size_d;
   logic                    uns_q, uns_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   rd0_q, rd0_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

   logic [2:0]              off;
   logic [15:0]             full_mask;
   logic                    split;
   logic [ADDR_WIDTH-4:0]   w0, w1;
   logic [DATA_WIDTH-1:0]   data0, data1;

   // Align the raw RAM word(s) to byte 0, truncate to the access size and extend.
   // Split accesses always have off != 0, so the hi shift stays below 64.
   function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [DATA_WIDTH-1:0] rd0,
      input logic [DATA_WIDTH-1:0] rd1,
      input logic                  is_split,
      input logic [2:0]            o,
      input logic [1:0]            sz,
      input logic                  uns
   );
      logic [DATA_WIDTH-1:0] lo, hi, raw, ext;
      lo  = rd0 >> {o, 3'b000};
      hi  = is_split ? (rd1 << (7'd64 - {1'b0, o, 3'b000})) : '0;
      raw = lo | hi;
      case (sz)
         2'd0:    ext = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
         2'd1:    ext = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
         2'd2:    ext = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
         default: ext = raw;
      endcase
      return ext;
   endfunction

   // Address, mask and store-data decode of the latched request.
   always_comb begin
      off = addr_q[2:0];
      case (size_q)
         2'd0:    full_mask = 16'h0001;
         2'd1:    full_mask = 16'h0003;
         2'd2:    full_mask = 16'h000F;
         default: full_mask = 16'h00FF;
      endcase
      full_mask = full_mask << off;
      split     = |full_mask[15:8];
      w0        = addr_q[ADDR_WIDTH-1:3];
      w1        = w0 + (ADDR_WIDTH-3)'(1);
      data0     = wdata_q << {off, 3'b000};
      data1     = (off == 3'd0) ? '0 : (wdata_q >> (7'd64 - {1'b0, off, 3'b000}));
   end

   // State and request registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rd0_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rd0_q   <= rd0_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic and RAM/handshake outputs.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      wdata_d     = wdata_q;
      rd0_d       = rd0_q;
      rdata_d     = rdata_q;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rd_addr   = '0;
      o_rd_en     = 1'b0;
      o_rd_mask   = '0;
      o_wr_addr   = '0;
      o_wr_en     = 1'b0;
      o_wr_mask   = '0;
      o_wr_data   = '0;
      case (state_q)
         S_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               we_d    = i_req_we;
               addr_d  = i_req_addr;
               size_d  = i_req_size;
               uns_d   = i_req_unsigned;
               wdata_d = i_req_wdata;
               state_d = S_ACC0;
            end
         end
         S_ACC0: begin
            if (we_q) begin
               o_wr_en   = 1'b1;
               o_wr_addr = {w0, 3'b000};
               o_wr_mask = full_mask[7:0];
               o_wr_data = data0;
               rdata_d   = '0;
            end else begin
               o_rd_en   = 1'b1;
               o_rd_addr = {w0, 3'b000};
               o_rd_mask = full_mask[7:0];
               rd0_d     = i_rd_data;
               rdata_d   = load_extend(i_rd_data, '0, 1'b0, off, size_q, uns_q);
            end
            state_d = split ? S_ACC1 : S_RESP;
         end
         S_ACC1: begin
            if (we_q) begin
               o_wr_en   = 1'b1;
               o_wr_addr = {w1, 3'b000};
               o_wr_mask = full_mask[15:8];
               o_wr_data = data1;
               rdata_d   = '0;
            end else begin
               o_rd_en   = 1'b1;
               o_rd_addr = {w1, 3'b000};
               o_rd_mask = full_mask[15:8];
               rdata_d   = load_extend(rd0_q, i_rd_data, 1'b1, off, size_q, uns_q);
            end
            state_d = S_RESP;
         end
         default: begin
            o_rsp_valid = 1'b1;
            if (i_rsp_ready) state_d = S_IDLE;
         end
      endcase
   end

   assign o_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-masked RAM model on the RAM side, byte-array reference
// memory for expected load data and per-byte expected RAM accesses.
module tb_lsu;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [9:0]  i_req_addr;
   logic [1:0]  i_req_size;
   logic        i_req_unsigned;
   logic [63:0] i_req_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [63:0] o_rsp_rdata;
   logic [9:0]  o_rd_addr;
   logic        o_rd_en;
   logic [7:0]  o_rd_mask;
   logic [63:0] i_rd_data;
   logic [9:0]  o_wr_addr;
   logic        o_wr_en;
   logic [7:0]  o_wr_mask;
   logic [63:0] o_wr_data;

   always #5 i_clk = ~i_clk;

   lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(10)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
      .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
      .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en), .o_rd_mask(o_rd_mask), .i_rd_data(i_rd_data),
      .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en), .o_wr_mask(o_wr_mask), .o_wr_data(o_wr_data)
   );

   // RAM the DUT drives: byte-masked writes at the clock edge, combinational read.
   logic [63:0] ram [128];
   logic        clr_ram;
   always @(posedge i_clk) begin
      if (clr_ram) begin
         for (int w = 0; w < 128; w++) ram[w] <= '0;
      end else if (o_wr_en) begin
         for (int b = 0; b < 8; b++)
            if (o_wr_mask[b]) ram[o_wr_addr[9:3]][8*b +: 8] <= o_wr_data[8*b +: 8];
      end
   end
   assign i_rd_data = ram[o_rd_addr[9:3]];

   logic [7:0]  ref_mem [1024];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [9:0]  obs_addr [2];
   logic [7:0]  obs_mask [2];
   logic [63:0] obs_data [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_load(input logic [9:0] addr, input logic [1:0] size,
                                              input bit uns);
      int n = 1 << size;
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 1024];
      if (!uns && size != 2'd3 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      return v;
   endfunction

   // One complete request: issue, observe RAM cycles, hold the response for bp
   // cycles (optionally with a competing request pending), then handshake.
   task automatic do_req(input bit we, input logic [9:0] addr, input logic [1:0] size,
                         input bit uns, input logic [63:0] wdata, input int bp,
                         input bit pend, output logic [63:0] rdata);
      int n = 1 << size;
      int off = int'(addr[2:0]);
      int nacc = (off + n > 8) ? 2 : 1;
      int lat = 0;
      int obs_n = 0;
      bit got_rsp = 0;
      logic [9:0]  e_addr [2];
      logic [7:0]  e_mask [2];
      logic [63:0] e_data [2];
      logic [63:0] e_rsp;
      for (int k = 0; k < 2; k++) begin
         e_addr[k] = '0; e_mask[k] = '0; e_data[k] = '0;
         obs_addr[k] = '0; obs_mask[k] = '0; obs_data[k] = '0;
      end
      for (int i = 0; i < n; i++) begin
         int a = (int'(addr) + i) % 1024;
         int k = (off + i >= 8) ? 1 : 0;
         e_addr[k] = 10'((a / 8) * 8);
         e_mask[k][a % 8] = 1'b1;
         e_data[k][8*(a % 8) +: 8] = wdata[8*i +: 8];
      end

      check("idle_ready", o_req_ready, 1);
      i_req_valid = 1; i_req_we = we; i_req_addr = addr; i_req_size = size;
      i_req_unsigned = uns; i_req_wdata = wdata;
      @(posedge i_clk); #1;
      i_req_valid = 0; i_req_addr = 10'($urandom); i_req_wdata = {$urandom, $urandom};
      i_req_size = 2'($urandom); i_req_we = ~we;

      for (int c = 0; c < 8 && !got_rsp; c++) begin
         @(negedge i_clk);
         lat++;
         if (o_rsp_valid) got_rsp = 1;
         else begin
            check("busy_not_ready", o_req_ready, 0);
            if (we) check("store_no_rd", o_rd_en, 0);
            else    check("load_no_wr", o_wr_en, 0);
            if (o_rd_en || o_wr_en) begin
               if (obs_n < 2) begin
                  obs_addr[obs_n] = we ? o_wr_addr : o_rd_addr;
                  obs_mask[obs_n] = we ? o_wr_mask : o_rd_mask;
                  obs_data[obs_n] = o_wr_data;
               end
               obs_n++;
            end
         end
      end
      check("rsp_valid_seen", o_rsp_valid, 1);
      check("rsp_latency", lat, nacc + 1);
      check("acc_count", obs_n, nacc);
      for (int k = 0; k < nacc; k++) begin
         logic [63:0] lanes = '0;
         for (int b = 0; b < 8; b++) if (e_mask[k][b]) lanes[8*b +: 8] = 8'hFF;
         check(k == 0 ? "acc0_addr" : "acc1_addr", obs_addr[k], e_addr[k]);
         check(k == 0 ? "acc0_mask" : "acc1_mask", obs_mask[k], e_mask[k]);
         if (we) check(k == 0 ? "acc0_wdata" : "acc1_wdata", obs_data[k] & lanes, e_data[k]);
      end

      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % 1024] = wdata[8*i +: 8];
         e_rsp = '0;
      end else begin
         e_rsp = model_load(addr, size, uns);
      end

      if (pend) begin
         i_req_valid = 1; i_req_we = 1; i_req_addr = 10'h000; i_req_size = 2'd3;
         i_req_wdata = 64'hDEADBEEFDEADBEEF;
      end
      for (int b = 0; b < bp; b++) begin
         check("bp_rsp_valid", o_rsp_valid, 1);
         check("bp_rdata", o_rsp_rdata, e_rsp);
         check("bp_not_ready", o_req_ready, 0);
         check("bp_no_ram", {o_rd_en, o_wr_en}, 0);
         @(negedge i_clk);
      end
      check("rsp_rdata", o_rsp_rdata, e_rsp);
      rdata = o_rsp_rdata;
      i_rsp_ready = 1;
      @(posedge i_clk); #1;
      i_rsp_ready = 0;
      i_req_valid = 0;
      @(negedge i_clk);
      check("post_rsp_valid", o_rsp_valid, 0);
      check("post_ready", o_req_ready, 1);
      check("post_no_ram", {o_rd_en, o_wr_en}, 0);
   endtask

   initial begin
      logic [63:0] r;
      i_rst_n = 0; clr_ram = 1;
      i_req_valid = 0; i_req_we = 0; i_req_addr = '0; i_req_size = '0;
      i_req_unsigned = 0; i_req_wdata = '0; i_rsp_ready = 0;
      for (int a = 0; a < 1024; a++) ref_mem[a] = '0;
      repeat (3) @(negedge i_clk);
      check("rst_ready", o_req_ready, 1);
      check("rst_rsp_valid", o_rsp_valid, 0);
      check("rst_rdata", o_rsp_rdata, 0);
      check("rst_ram_en", {o_rd_en, o_wr_en}, 0);
      check("rst_ram_bus", {o_rd_addr, o_rd_mask, o_wr_addr, o_wr_mask}, 0);
      check("rst_wr_data", o_wr_data, 0);
      i_rst_n = 1; clr_ram = 0;
      @(negedge i_clk);

      // Directed cases.
      do_req(1, 10'h010, 2'd3, 0, 64'h1122334455667788, 0, 0, r);
      check("sd_addr", obs_addr[0], 10'h010);
      check("sd_mask", obs_mask[0], 8'hFF);
      do_req(0, 10'h010, 2'd3, 0, '0, 0, 0, r); check("ld_val", r, 64'h1122334455667788);
      do_req(0, 10'h010, 2'd0, 0, '0, 0, 0, r); check("lb_val", r, 64'hFFFFFFFFFFFFFF88);
      do_req(0, 10'h010, 2'd0, 1, '0, 0, 0, r); check("lbu_val", r, 64'h88);
      do_req(0, 10'h016, 2'd1, 0, '0, 0, 0, r); check("lh_val", r, 64'h1122);
      do_req(0, 10'h014, 2'd2, 0, '0, 0, 0, r); check("lw_val", r, 64'h11223344);
      do_req(1, 10'h01E, 2'd2, 0, 64'hAABBCCDD, 0, 0, r);
      check("sw_split_a0", obs_addr[0], 10'h018);
      check("sw_split_m0", obs_mask[0], 8'hC0);
      check("sw_split_d0", obs_data[0][63:48], 16'hAABB ^ 16'h6666);
      check("sw_split_a1", obs_addr[1], 10'h020);
      check("sw_split_m1", obs_mask[1], 8'h03);
      check("sw_split_d1", obs_data[1][15:0], 16'hAABB);
      do_req(0, 10'h01E, 2'd2, 0, '0, 0, 0, r); check("lw_split_val", r, 64'hFFFFFFFFAABBCCDD);
      do_req(1, 10'h3FF, 2'd1, 0, 64'h1234, 0, 0, r);
      check("sh_wrap_a0", obs_addr[0], 10'h3F8);
      check("sh_wrap_m0", obs_mask[0], 8'h80);
      check("sh_wrap_d0", obs_data[0][63:56], 8'h34);
      check("sh_wrap_a1", obs_addr[1], 10'h000);
      check("sh_wrap_m1", obs_mask[1], 8'h01);
      check("sh_wrap_d1", obs_data[1][7:0], 8'h12);
      do_req(0, 10'h3FF, 2'd1, 1, '0, 0, 0, r); check("lhu_wrap_val", r, 64'h1234);
      do_req(0, 10'h014, 2'd2, 1, '0, 4, 1, r); check("bp_val", r, 64'h11223344);
      do_req(0, 10'h000, 2'd3, 0, '0, 0, 0, r); check("pend_not_taken", r, 64'h12);

      // Reset while the response is being held.
      i_req_valid = 1; i_req_we = 0; i_req_addr = 10'h010; i_req_size = 2'd3;
      @(posedge i_clk); #1; i_req_valid = 0;
      for (int c = 0; c < 6 && !o_rsp_valid; c++) @(negedge i_clk);
      check("rstmid_in_resp", o_rsp_valid, 1);
      #2 i_rst_n = 0;
      #1;
      check("rstmid_rsp_valid", o_rsp_valid, 0);
      check("rstmid_ready", o_req_ready, 1);
      check("rstmid_ram_en", {o_rd_en, o_wr_en}, 0);
      @(negedge i_clk); i_rst_n = 1;
      @(negedge i_clk);
      check("rstmid_after_valid", o_rsp_valid, 0);
      check("rstmid_after_ready", o_req_ready, 1);

      // Randomized traffic against the byte-array reference.
      for (int t = 0; t < 200; t++) begin
         logic [9:0] a;
         case ($urandom_range(0, 2))
            0:       a = 10'($urandom_range(0, 63));
            1:       a = 10'($urandom_range(1008, 1023));
            default: a = 10'($urandom);
         endcase
         do_req(bit'($urandom_range(0, 1)), a, 2'($urandom), bit'($urandom_range(0, 1)),
                {$urandom, $urandom}, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
